// File: rtl/tmds_encoder_pkg.sv
// Shared HDMI constants: TMDS control tokens, disparity width, 720p line timing,
// and the stage-1 transition-minimising helper.
package tmds_encoder_pkg;

  localparam int CNT_W = 5;

  localparam logic [9:0] TOK_C00 = 10'b1101010100;
  localparam logic [9:0] TOK_C01 = 10'b0010101011;
  localparam logic [9:0] TOK_C10 = 10'b0101010100;
  localparam logic [9:0] TOK_C11 = 10'b1010101011;

  // 1280x720@60 horizontal timing (front porch + sync + back porch = blanking)
  localparam int H_ACTIVE = 1280;
  localparam int H_FRONT  = 110;
  localparam int H_SYNC   = 40;
  localparam int H_BACK   = 220;
  localparam int H_BLANK  = H_FRONT + H_SYNC + H_BACK;
  localparam int H_TOTAL  = H_ACTIVE + H_BLANK;

  function automatic logic [8:0] tmds_qm(input logic [7:0] d, input logic use_xnor);
    logic [8:0] q;
    q    = 9'd0;
    q[0] = d[0];
    for (int i = 1; i < 8; i++) begin
      q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
    end
    q[8] = ~use_xnor;
    return q;
  endfunction

  function automatic logic [9:0] control_token(input logic [1:0] c);
    logic [9:0] t;
    case (c)
      2'b00:   t = TOK_C00;
      2'b01:   t = TOK_C01;
      2'b10:   t = TOK_C10;
      2'b11:   t = TOK_C11;
      default: t = TOK_C00;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/tmds_encoder_popcount8.sv
// Combinational count of ones in an 8-bit word.
module tmds_popcount8 (
  input  logic [7:0] a,
  output logic [3:0] ones
);

  always_comb begin
    ones = 4'd0;
    for (int i = 0; i < 8; i++) begin
      ones = ones + {3'd0, a[i]};
    end
  end

endmodule

// File: rtl/tmds_encoder.sv
// DVI 1.0 TMDS 8b/10b encoder: input register, q_m stage, DC-balancing output stage.
import tmds_encoder_pkg::*;

module tmds_encoder (
  input  logic       clk,
  input  logic       rst,
  input  logic       de,
  input  logic [7:0] din,
  input  logic       c0,
  input  logic       c1,
  output logic [9:0] dout
);

  logic                    de0_q, de0_d;
  logic [7:0]              din0_q, din0_d;
  logic [1:0]              ctl0_q, ctl0_d;
  logic [8:0]              qm1_q, qm1_d;
  logic                    de1_q, de1_d;
  logic [1:0]              ctl1_q, ctl1_d;
  logic [9:0]              dout_q, dout_d;
  logic signed [CNT_W-1:0] cnt_q, cnt_d;

  logic [3:0]              n1_din;
  logic [3:0]              n1_qm;
  logic                    use_xnor;
  logic signed [CNT_W-1:0] n1_s, n0_s, balance_s, qm8_x2_s, not_qm8_x2_s;

  tmds_popcount8 u_pop_din (.a(din0_q),      .ones(n1_din));
  tmds_popcount8 u_pop_qm  (.a(qm1_q[7:0]),  .ones(n1_qm));

  always_comb begin
    de0_d  = de;
    din0_d = din;
    ctl0_d = {c1, c0};

    use_xnor = (n1_din > 4'd4) || ((n1_din == 4'd4) && (din0_q[0] == 1'b0));
    qm1_d    = tmds_qm(din0_q, use_xnor);
    de1_d    = de0_q;
    ctl1_d   = ctl0_q;

    n1_s         = $signed({1'b0, n1_qm});
    n0_s         = 5'sd8 - n1_s;
    balance_s    = n1_s - n0_s;
    qm8_x2_s     = qm1_q[8] ? 5'sd2 : 5'sd0;
    not_qm8_x2_s = qm1_q[8] ? 5'sd0 : 5'sd2;

    // Disparity stays within -8..+8, so 5-bit signed sums never wrap
    if (!de1_q) begin
      dout_d = control_token(ctl1_q);
      cnt_d  = 5'sd0;
    end else if ((cnt_q == 5'sd0) || (balance_s == 5'sd0)) begin
      if (qm1_q[8]) begin
        dout_d = {2'b01, qm1_q[7:0]};
        cnt_d  = cnt_q + balance_s;
      end else begin
        dout_d = {2'b10, ~qm1_q[7:0]};
        cnt_d  = cnt_q - balance_s;
      end
    end else if (((cnt_q > 5'sd0) && (balance_s > 5'sd0)) ||
                 ((cnt_q < 5'sd0) && (balance_s < 5'sd0))) begin
      dout_d = {1'b1, qm1_q[8], ~qm1_q[7:0]};
      cnt_d  = cnt_q + qm8_x2_s - balance_s;
    end else begin
      dout_d = {1'b0, qm1_q[8], qm1_q[7:0]};
      cnt_d  = cnt_q + balance_s - not_qm8_x2_s;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      de0_q  <= 1'b0;
      din0_q <= 8'd0;
      ctl0_q <= 2'd0;
      qm1_q  <= 9'd0;
      de1_q  <= 1'b0;
      ctl1_q <= 2'd0;
      dout_q <= 10'd0;
      cnt_q  <= 5'sd0;
    end else begin
      de0_q  <= de0_d;
      din0_q <= din0_d;
      ctl0_q <= ctl0_d;
      qm1_q  <= qm1_d;
      de1_q  <= de1_d;
      ctl1_q <= ctl1_d;
      dout_q <= dout_d;
      cnt_q  <= cnt_d;
    end
  end

  assign dout = dout_q;

endmodule
